// File: rtl/ber_exp_sampler_if.sv
// ber_exp_sampler_if: request, approxexp, random-byte and result channels of the Bernoulli sampler (stats ports with BER_EXP_STATS_EN)
interface ber_exp_sampler_if #(
  parameter int Z_W = 64
`ifdef BER_EXP_STATS_EN
  , parameter int STAT_CNT_W = 16
`endif
);
  logic           in_val, in_rdy;
  logic [Z_W-1:0] r_i, ccs_i;
  logic [6:0]     s_i;
  logic           exp_din_val, exp_din_rdy;
  logic [Z_W-1:0] exp_x_o, exp_ccs_o;
  logic           exp_dout_val, exp_dout_rdy;
  logic [Z_W-1:0] exp_i;
  logic           rnd_val, rnd_rdy;
  logic [7:0]     rnd_byte;
  logic           dout_val, dout_rdy, accept_o;
`ifdef BER_EXP_STATS_EN
  logic [STAT_CNT_W-1:0] stat_req_o, stat_acc_o, stat_bytes_o;
`endif
  modport master (
`ifdef BER_EXP_STATS_EN
    output stat_req_o, stat_acc_o, stat_bytes_o,
`endif
    input  in_val, r_i, s_i, ccs_i, exp_din_rdy, exp_dout_val, exp_i, rnd_val, rnd_byte, dout_rdy,
    output in_rdy, exp_din_val, exp_x_o, exp_ccs_o, exp_dout_rdy, rnd_rdy, dout_val, accept_o
  );
  modport slave (
`ifdef BER_EXP_STATS_EN
    input  stat_req_o, stat_acc_o, stat_bytes_o,
`endif
    output in_val, r_i, s_i, ccs_i, exp_din_rdy, exp_dout_val, exp_i, rnd_val, rnd_byte, dout_rdy,
    input  in_rdy, exp_din_val, exp_x_o, exp_ccs_o, exp_dout_rdy, rnd_rdy, dout_val, accept_o
  );
endinterface

// File: rtl/ber_exp_sampler.sv
// ber_exp_sampler: Bernoulli sampler; z = (2*exp-1)>>min(s,63) compared MSB-first to random bytes (ports: clk, rst, bus.master; BER_EXP_STATS_EN adds counters)
module ber_exp_sampler #(
  parameter int Z_W = 64
`ifdef BER_EXP_STATS_EN
  , parameter int STAT_CNT_W = 16
`endif
) (
  input logic clk,
  input logic rst,
  ber_exp_sampler_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ZCALC, CMP, DONE} state_t;
  state_t         state;
  logic [Z_W-1:0] r_q, ccs_q, exp_q, z_q;
  logic [5:0]     s_q;
  logic [2:0]     idx;
  logic [7:0]     zb;
  logic           rnd_hs;
  assign zb = z_q[{idx, 3'b000} +: 8];
  assign rnd_hs = bus.rnd_val && bus.rnd_rdy;
  assign bus.exp_x_o = r_q;
  assign bus.exp_ccs_o = ccs_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.in_rdy <= 1'b1;
      bus.exp_din_val <= 1'b0;
      bus.exp_dout_rdy <= 1'b0;
      bus.rnd_rdy <= 1'b0;
      bus.dout_val <= 1'b0;
      bus.accept_o <= 1'b0;
      r_q <= '0;
      ccs_q <= '0;
      exp_q <= '0;
      z_q <= '0;
      s_q <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_val && bus.in_rdy) begin
          r_q <= bus.r_i;
          ccs_q <= bus.ccs_i;
          s_q <= (bus.s_i > 7'd63) ? 6'd63 : bus.s_i[5:0];
          bus.in_rdy <= 1'b0;
          bus.exp_din_val <= 1'b1;
          state <= REQ;
        end
        REQ: if (bus.exp_din_rdy) begin
          bus.exp_din_val <= 1'b0;
          bus.exp_dout_rdy <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (bus.exp_dout_val) begin
          exp_q <= bus.exp_i;
          bus.exp_dout_rdy <= 1'b0;
          state <= ZCALC;
        end
        ZCALC: begin
          // exp_q = 0 wraps to all-ones before the shift
          z_q <= ((exp_q << 1) - 1'b1) >> s_q;
          idx <= 3'd7;
          bus.rnd_rdy <= 1'b1;
          state <= CMP;
        end
        CMP: if (rnd_hs) begin
          if (bus.rnd_byte != zb || idx == 3'd0) begin
            bus.accept_o <= bus.rnd_byte < zb;
            bus.rnd_rdy <= 1'b0;
            bus.dout_val <= 1'b1;
            state <= DONE;
          end else idx <= idx - 3'd1;
        end
        DONE: if (bus.dout_rdy) begin
          bus.dout_val <= 1'b0;
          bus.accept_o <= 1'b0;
          bus.in_rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BER_EXP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stat_req_o <= '0;
      bus.stat_acc_o <= '0;
      bus.stat_bytes_o <= '0;
    end else begin
      if (state == DONE && bus.dout_rdy && !(&bus.stat_req_o)) bus.stat_req_o <= bus.stat_req_o + 1'b1;
      if (state == DONE && bus.dout_rdy && bus.accept_o && !(&bus.stat_acc_o)) bus.stat_acc_o <= bus.stat_acc_o + 1'b1;
      if (state == CMP && rnd_hs && !(&bus.stat_bytes_o)) bus.stat_bytes_o <= bus.stat_bytes_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ber_exp_sampler.sv
// tb_ber_exp_sampler: directed and randomized checks of ber_exp_sampler against an arithmetic reference model
module tb_ber_exp_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int m_req = 0, m_acc = 0, m_bytes = 0;
  ber_exp_sampler_if bus ();
  ber_exp_sampler dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // z as a 64-bit fraction; the byte stream is a uniform 64-bit fraction u read MSB-first
  function automatic logic [63:0] zmodel(input logic [63:0] e, input logic [6:0] s);
    logic [63:0] t;
    t = e * 64'd2 - 64'd1;
    return t >> ((s > 7'd63) ? 7'd63 : s);
  endfunction

  function automatic int nbytes(input logic [63:0] u, input logic [63:0] z);
    for (int i = 0; i < 8; i++)
      if (8'((u ^ z) >> (56 - 8 * i)) != 8'd0) return i + 1;
    return 8;
  endfunction

  task automatic chk_stats;
`ifdef BER_EXP_STATS_EN
    chk("stat_req", 64'(bus.stat_req_o), 64'(m_req));
    chk("stat_acc", 64'(bus.stat_acc_o), 64'(m_acc));
    chk("stat_bytes", 64'(bus.stat_bytes_o), 64'(m_bytes));
`endif
  endtask

  task automatic to_cmp(input logic [63:0] e, input logic [6:0] s);
    logic [63:0] r, c;
    r = rnd64();
    c = rnd64();
    chk("in_rdy_idle", 64'(bus.in_rdy), 64'd1);
    bus.in_val = 1'b1; bus.r_i = r; bus.s_i = s; bus.ccs_i = c;
    tick;
    bus.in_val = 1'b0; bus.r_i = rnd64(); bus.s_i = 7'($urandom); bus.ccs_i = rnd64();
    chk("in_rdy_busy", 64'(bus.in_rdy), 64'd0);
    repeat ($urandom_range(0, 2)) tick;
    chk("exp_din_val", 64'(bus.exp_din_val), 64'd1);
    chk("exp_x", bus.exp_x_o, r);
    chk("exp_ccs", bus.exp_ccs_o, c);
    bus.exp_din_rdy = 1'b1;
    tick;
    bus.exp_din_rdy = 1'b0;
    chk("exp_din_drop", 64'(bus.exp_din_val), 64'd0);
    repeat ($urandom_range(0, 3)) tick;
    chk("exp_dout_rdy", 64'(bus.exp_dout_rdy), 64'd1);
    bus.exp_dout_val = 1'b1; bus.exp_i = e;
    tick;
    bus.exp_dout_val = 1'b0; bus.exp_i = rnd64();
    chk("zcalc_rnd_rdy", 64'(bus.rnd_rdy), 64'd0);
    tick;
    chk("cmp_rnd_rdy", 64'(bus.rnd_rdy), 64'd1);
  endtask

  task automatic do_req(input logic [63:0] e, input logic [6:0] s, input logic [63:0] u, input bit gaps, input int hold, input string tag);
    logic [63:0] z;
    int used, cyc;
    bit hs, acc;
    z = zmodel(e, s);
    acc = u < z;
    to_cmp(e, s);
    used = 0;
    cyc = 0;
    while (!bus.dout_val && cyc < 100 && used < 8) begin
      bus.rnd_val = gaps ? 1'($urandom) : 1'b1;
      bus.rnd_byte = 8'(u >> (56 - 8 * used));
      hs = bus.rnd_val && bus.rnd_rdy;
      tick;
      if (hs) used++;
      cyc++;
    end
    bus.rnd_val = 1'b0;
    chk({tag, "_dout_val"}, 64'(bus.dout_val), 64'd1);
    chk({tag, "_accept"}, 64'(bus.accept_o), 64'(acc));
    chk({tag, "_bytes"}, 64'(used), 64'(nbytes(u, z)));
    m_bytes += used;
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_val"}, 64'(bus.dout_val), 64'd1);
      chk({tag, "_hold_acc"}, 64'(bus.accept_o), 64'(acc));
      chk({tag, "_hold_in_rdy"}, 64'(bus.in_rdy), 64'd0);
    end
    bus.dout_rdy = 1'b1;
    tick;
    bus.dout_rdy = 1'b0;
    m_req++;
    if (acc) m_acc++;
    chk({tag, "_dout_clr"}, 64'(bus.dout_val), 64'd0);
    chk({tag, "_in_rdy_back"}, 64'(bus.in_rdy), 64'd1);
    chk_stats();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_rdy"}, 64'(bus.in_rdy), 64'd1);
    chk({tag, "_exp_din_val"}, 64'(bus.exp_din_val), 64'd0);
    chk({tag, "_exp_dout_rdy"}, 64'(bus.exp_dout_rdy), 64'd0);
    chk({tag, "_rnd_rdy"}, 64'(bus.rnd_rdy), 64'd0);
    chk({tag, "_dout_val"}, 64'(bus.dout_val), 64'd0);
    chk({tag, "_accept"}, 64'(bus.accept_o), 64'd0);
  endtask

  initial begin
    logic [63:0] e, u, z;
    logic [6:0] s;
    int k;
    bus.in_val = 0; bus.r_i = 0; bus.s_i = 0; bus.ccs_i = 0;
    bus.exp_din_rdy = 0; bus.exp_dout_val = 0; bus.exp_i = 0;
    bus.rnd_val = 0; bus.rnd_byte = 0; bus.dout_rdy = 0;
    tick; tick;
    chk_idle("reset");
    chk("reset_exp_x", bus.exp_x_o, 64'd0);
    rst = 1'b0;
    tick;
    chk_stats();
    do_req(64'h8000_0000_0000_0000, 7'd0, 64'h0000_0000_0000_0000, 1'b0, 0, "t1");
    do_req(64'h4000_0000_0000_0000, 7'd1, 64'h4000_0000_0000_0000, 1'b0, 0, "t2");
    do_req(64'h8000_0000_0000_0000, 7'd70, 64'h0000_0000_0000_0000, 1'b0, 0, "t3a");
    do_req(64'h8000_0000_0000_0000, 7'd70, 64'h0000_0000_0000_0001, 1'b0, 0, "t3b");
    do_req(64'h0000_0000_0000_0000, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "t4");
    do_req(64'h8000_0000_0000_0000, 7'd63, 64'h0000_0000_0000_0000, 1'b1, 5, "t5");
    // reset in CMP after three equal bytes, then a stale approxexp result
    to_cmp(64'h8000_0000_0000_0000, 7'd63);
    bus.rnd_byte = 8'h00;
    bus.rnd_val = 1'b1;
    repeat (3) tick;
    bus.rnd_val = 1'b0;
    chk("mid_dout_val", 64'(bus.dout_val), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_req = 0; m_acc = 0; m_bytes = 0;
    chk_idle("rst_mid");
    chk_stats();
    bus.exp_dout_val = 1'b1; bus.exp_i = rnd64();
    tick;
    bus.exp_dout_val = 1'b0;
    chk_idle("late_res");
    do_req(64'h8000_0000_0000_0000, 7'd0, 64'h0100_0000_0000_0000, 1'b0, 1, "post_rst");
    for (int n = 0; n < 25; n++) begin
      e = rnd64();
      s = 7'($urandom_range(0, 80));
      z = zmodel(e, s);
      k = $urandom_range(0, 8);
      u = z;
      if (k < 8) u[8 * k +: 8] = 8'($urandom);
      if (n % 3 == 0) u = rnd64();
      do_req(e, s, u, n % 2 == 1, $urandom_range(0, 2), "rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
